// File: rtl/logic_proc_pkg.sv
// rtl/logic_proc_pkg.sv - shared types and defaults for the serial logic processor
package logic_proc_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_XOR  = 3'b010,
    F_ONE  = 3'b011,
    F_NAND = 3'b100,
    F_NOR  = 3'b101,
    F_XNOR = 3'b110,
    F_ZERO = 3'b111
  } func_t;

  typedef enum logic [1:0] {
    R_ROTATE = 2'b00,
    R_B_FB   = 2'b01,
    R_A_FB   = 2'b10,
    R_SWAP   = 2'b11
  } route_t;

endpackage

// File: rtl/bit_compute.sv
// rtl/bit_compute.sv - per-bit function and shift-in routing, purely combinational
module bit_compute
  import logic_proc_pkg::*;
(
  input  logic   A_bit,
  input  logic   B_bit,
  input  func_t  f_sel,
  input  route_t r_sel,
  output logic   A_In,
  output logic   B_In
);

  logic fb;

  always_comb begin
    fb = 1'b0;
    case (f_sel)
      F_AND:   fb = A_bit & B_bit;
      F_OR:    fb = A_bit | B_bit;
      F_XOR:   fb = A_bit ^ B_bit;
      F_ONE:   fb = 1'b1;
      F_NAND:  fb = ~(A_bit & B_bit);
      F_NOR:   fb = ~(A_bit | B_bit);
      F_XNOR:  fb = ~(A_bit ^ B_bit);
      F_ZERO:  fb = 1'b0;
      default: fb = 1'b0;
    endcase
  end

  // Registers not receiving fb rotate their own bit back in so they come out unchanged
  always_comb begin
    A_In = A_bit;
    B_In = B_bit;
    case (r_sel)
      R_ROTATE: begin A_In = A_bit; B_In = B_bit; end
      R_B_FB:   begin A_In = A_bit; B_In = fb;    end
      R_A_FB:   begin A_In = fb;    B_In = B_bit; end
      R_SWAP:   begin A_In = B_bit; B_In = A_bit; end
      default:  begin A_In = A_bit; B_In = B_bit; end
    endcase
  end

endmodule

// File: rtl/serial_logic_ctrl.sv
// rtl/serial_logic_ctrl.sv - load/shift sequencing and F/R latching for the two shift registers
module serial_logic_ctrl
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_bit,
  input  logic       B_bit,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic       A_In,
  output logic       B_In,
  output logic       Busy,
  output logic       Done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  func_t            f_q;
  route_t           r_q;
  logic             done_first;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      f_q        <= F_AND;
      r_q        <= R_ROTATE;
      done_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Done is only the first DONE cycle, so mark the SHIFT->DONE entry
      done_first <= (state == SHIFT) && (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (Execute) begin
            f_q <= func_t'(F);
            r_q <= route_t'(R);
            cnt <= '0;
          end
        end
        SHIFT:   cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    Ld_A      = 1'b0;
    Ld_B      = 1'b0;
    Shift_En  = 1'b0;
    Done      = 1'b0;
    Busy      = (state != IDLE);
    case (state)
      IDLE: begin
        Ld_A = LoadA & ~Execute;
        Ld_B = LoadB & ~Execute;
        if (Execute) state_nxt = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        Done = done_first;
        if (!Execute) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  bit_compute u_bit_compute (
    .A_bit (A_bit),
    .B_bit (B_bit),
    .f_sel (f_q),
    .r_sel (r_q),
    .A_In  (A_In),
    .B_In  (B_In)
  );

endmodule

// File: tb/tb_serial_logic_ctrl.sv
// tb/tb_serial_logic_ctrl.sv - directed bench with two 8-bit shift registers around serial_logic_ctrl
module tb_serial_logic_ctrl;
  import logic_proc_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       Execute;
  logic       LoadA;
  logic       LoadB;
  logic [2:0] F;
  logic [1:0] R;
  logic       A_bit;
  logic       B_bit;
  logic       Ld_A;
  logic       Ld_B;
  logic       Shift_En;
  logic       A_In;
  logic       B_In;
  logic       Busy;
  logic       Done;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] a_load;
  logic [7:0] b_load;

  int pass_cnt;
  int total_cnt;

  serial_logic_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Execute  (Execute),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .F        (F),
    .R        (R),
    .A_bit    (A_bit),
    .B_bit    (B_bit),
    .Ld_A     (Ld_A),
    .Ld_B     (Ld_B),
    .Shift_En (Shift_En),
    .A_In     (A_In),
    .B_In     (B_In),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shift registers: LSB out, shift-in at MSB
  always @(posedge Clk) begin
    if (Ld_A) a_reg <= a_load;
    else if (Shift_En) a_reg <= {A_In, a_reg[7:1]};
    if (Ld_B) b_reg <= b_load;
    else if (Shift_En) b_reg <= {B_In, b_reg[7:1]};
  end

  assign A_bit = a_reg[0];
  assign B_bit = b_reg[0];

  task automatic load_regs(input logic [7:0] av, input logic [7:0] bv);
    a_load = av;
    b_load = bv;
    LoadA  = 1'b1;
    LoadB  = 1'b1;
    @(negedge Clk);
    LoadA  = 1'b0;
    LoadB  = 1'b0;
  endtask

  // Runs one operation; Execute held for 'hold' cycles, F/R changed to nf/nr at cycle chg_at
  task automatic run_op(input logic [2:0] f, input logic [1:0] r, input int hold,
                        input int chg_at, input logic [2:0] nf, input logic [1:0] nr,
                        output int n_shift, output int n_done, output int n_busy,
                        output int first_shift, output int done_c);
    bit finished;
    F = f;
    R = r;
    Execute = 1'b1;
    n_shift = 0;
    n_done = 0;
    n_busy = 0;
    first_shift = -1;
    done_c = -1;
    finished = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clk);
      if (Shift_En) begin
        if (first_shift < 0) first_shift = c;
        n_shift++;
      end
      if (Done) begin
        if (done_c < 0) done_c = c;
        n_done++;
      end
      if (!Busy) begin
        finished = 1'b1;
        break;
      end
      n_busy++;
      if (c == chg_at) begin
        F = nf;
        R = nr;
      end
      if (c == hold - 1) Execute = 1'b0;
    end
    Execute = 1'b0;
    total_cnt++;
    if (finished !== 1'b1) $display("FAIL op_timeout: Busy still %b after 80 cycles, want 0", Busy);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    total_cnt++;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
    else pass_cnt++;
    total_cnt++;
    if ({Shift_En, Busy, Done} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {Shift_En, Busy, Done});
    else pass_cnt++;
    total_cnt++;
    if ({Ld_A, Ld_B} !== 2'b00) $display("FAIL reset_ld: got %b want 00", {Ld_A, Ld_B});
    else pass_cnt++;
    Reset = 1'b0;
    LoadA = 1'b1;
    #1;
    total_cnt++;
    if (Ld_A !== 1'b1) $display("FAIL idle_ld_a: got %b want 1", Ld_A);
    else pass_cnt++;
    LoadA = 1'b0;
  endtask

  task automatic test_and_route_a;
    int ns, nd, nb, fs, dc;
    load_regs(8'h33, 8'h55);
    run_op(3'b000, 2'b10, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if (ns !== 8) $display("FAIL t1_shift_count: got %0d want 8", ns);
    else pass_cnt++;
    total_cnt++;
    if (nd !== 1) $display("FAIL t1_done_count: got %0d want 1", nd);
    else pass_cnt++;
    total_cnt++;
    if (fs !== 0 || dc !== 8) $display("FAIL t1_latency: first shift %0d done %0d want 0 and 8", fs, dc);
    else pass_cnt++;
    total_cnt++;
    if (a_reg !== 8'h11) $display("FAIL t1_a: got %h want 11", a_reg);
    else pass_cnt++;
    total_cnt++;
    if (b_reg !== 8'h55) $display("FAIL t1_b: got %h want 55", b_reg);
    else pass_cnt++;
  endtask

  task automatic test_xor_xnor;
    int ns, nd, nb, fs, dc;
    load_regs(8'h33, 8'h55);
    run_op(3'b010, 2'b01, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if (a_reg !== 8'h33) $display("FAIL t2_xor_a: got %h want 33", a_reg);
    else pass_cnt++;
    total_cnt++;
    if (b_reg !== 8'h66) $display("FAIL t2_xor_b: got %h want 66", b_reg);
    else pass_cnt++;
    run_op(3'b110, 2'b10, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if (a_reg !== 8'hAA) $display("FAIL t2_xnor_a: got %h want aa", a_reg);
    else pass_cnt++;
    total_cnt++;
    if (b_reg !== 8'h66) $display("FAIL t2_xnor_b: got %h want 66", b_reg);
    else pass_cnt++;
  endtask

  task automatic test_swap_rotate;
    int ns, nd, nb, fs, dc;
    load_regs(8'h33, 8'h55);
    run_op(3'b000, 2'b11, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if ({a_reg, b_reg} !== 16'h5533) $display("FAIL t3_swap: got %h want 5533", {a_reg, b_reg});
    else pass_cnt++;
    run_op(3'b011, 2'b00, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if ({a_reg, b_reg} !== 16'h5533) $display("FAIL t3_rotate_one: got %h want 5533", {a_reg, b_reg});
    else pass_cnt++;
    run_op(3'b111, 2'b00, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if ({a_reg, b_reg} !== 16'h5533) $display("FAIL t3_rotate_zero: got %h want 5533", {a_reg, b_reg});
    else pass_cnt++;
  endtask

  task automatic test_hold_execute;
    int ns, nd, nb, fs, dc;
    load_regs(8'h0F, 8'hF0);
    run_op(3'b001, 2'b10, 30, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if (ns !== 8) $display("FAIL t4_hold_shifts: got %0d want 8", ns);
    else pass_cnt++;
    total_cnt++;
    if (nd !== 1) $display("FAIL t4_hold_done: got %0d want 1", nd);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 30) $display("FAIL t4_busy_cycles: got %0d want 30", nb);
    else pass_cnt++;
    total_cnt++;
    if (a_reg !== 8'hFF) $display("FAIL t4_or_a: got %h want ff", a_reg);
    else pass_cnt++;
    run_op(3'b000, 2'b01, 1, -1, 3'b000, 2'b00, ns, nd, nb, fs, dc);
    total_cnt++;
    if (ns !== 8 || nd !== 1) $display("FAIL t4_repress: shifts %0d done %0d want 8 and 1", ns, nd);
    else pass_cnt++;
    total_cnt++;
    if (b_reg !== 8'hF0) $display("FAIL t4_repress_b: got %h want f0", b_reg);
    else pass_cnt++;
  endtask

  task automatic test_change_mid_op;
    int ns, nd, nb, fs, dc;
    load_regs(8'h33, 8'h55);
    run_op(3'b000, 2'b10, 1, 2, 3'b001, 2'b01, ns, nd, nb, fs, dc);
    total_cnt++;
    if (a_reg !== 8'h11) $display("FAIL t5_a: got %h want 11", a_reg);
    else pass_cnt++;
    total_cnt++;
    if (b_reg !== 8'h55) $display("FAIL t5_b: got %h want 55", b_reg);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    bit idle_seen;
    load_regs(8'h33, 8'h55);
    F = 3'b000;
    R = 2'b10;
    Execute = 1'b1;
    @(negedge Clk);
    Execute = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    total_cnt++;
    if (Shift_En !== 1'b1) $display("FAIL t6_shift4: got %b want 1", Shift_En);
    else pass_cnt++;
    Reset = 1'b1;
    @(negedge Clk);
    total_cnt++;
    if ({Shift_En, Busy, Done} !== 3'b000) $display("FAIL t6_reset_ctrl: got %b want 000", {Shift_En, Busy, Done});
    else pass_cnt++;
    total_cnt++;
    if (dut.state !== IDLE || dut.cnt !== 3'd0) $display("FAIL t6_reset_state: state %0d cnt %0d want 0 and 0", dut.state, dut.cnt);
    else pass_cnt++;
    Reset = 1'b0;
    a_load = 8'hFF;
    LoadA = 1'b1;
    Execute = 1'b1;
    #1;
    total_cnt++;
    if (Ld_A !== 1'b0) $display("FAIL t6_ld_priority: got %b want 0", Ld_A);
    else pass_cnt++;
    @(negedge Clk);
    LoadA = 1'b0;
    Execute = 1'b0;
    total_cnt++;
    if ({Shift_En, Busy} !== 2'b11) $display("FAIL t6_exec_start: got %b want 11", {Shift_En, Busy});
    else pass_cnt++;
    idle_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (!Busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (idle_seen !== 1'b1) $display("FAIL t6_return_idle: Busy %b want 0 within 20 cycles", Busy);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    Reset     = 1'b1;
    Execute   = 1'b0;
    LoadA     = 1'b0;
    LoadB     = 1'b0;
    F         = 3'b000;
    R         = 2'b00;
    a_load    = 8'h00;
    b_load    = 8'h00;
    @(negedge Clk);
    test_reset();
    test_and_route_a();
    test_xor_xnor();
    test_swap_rotate();
    test_hold_execute();
    test_change_mid_op();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
